l1_dcache: RTL and testbench
============================

# l1_dcache

Two-way set-associative, write-back, write-allocate L1 data cache between the CPU pipeline's data-memory port and physical memory. It serves word and byte loads and stores, and it returns a read or write hit in the same cycle as the request, so the pipeline's global load is not stalled. On a miss it evicts the LRU way (writing it back first if dirty), then fills the 128-bit line from physical memory.

## Interface
Parameters: none. Geometry is fixed: 8 sets × 2 ways × 16-byte lines.

Ports (name, direction, width, meaning):
- clk  in  1  system clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mem_read  in  1  CPU load request; held until mem_resp
- mem_write  in  1  CPU store request; held until mem_resp
- mem_address  in  16  byte address: tag [15:7], index [6:4], word [3:1], byte [0]
- mem_wdata  in  16  store data, already byte-lane aligned
- mem_byte_enable  in  2  store lane mask; bit1 = high byte
- mem_rdata  out  16  addressed word of the hit line (combinational)
- mem_resp  out  1  request complete this cycle
- pmem_read  out  1  line fill request
- pmem_write  out  1  line writeback request
- pmem_address  out  16  line address, bits [3:0] = 0
- pmem_wdata  out  128  victim line
- pmem_rdata  in  128  fill line
- pmem_resp  in  1  physical memory transaction done

## Operation
- Per way and per set the block holds valid, dirty, a 9-bit tag and a 128-bit line. Per set it holds one LRU bit naming the way to evict next.
- Hit: valid[w][index] and tag[w][index] == mem_address[15:7]. Both ways cannot hit at once.
- FSM states: IDLE, WRITEBACK, ALLOCATE.
- IDLE:
  - Hit read: mem_rdata = line word [3:1]; mem_resp = 1; LRU = other way.
  - Hit write: for each lane with mem_byte_enable[i] = 1, write that byte of mem_wdata into the word. Set dirty, mem_resp = 1, LRU = other way.
  - Miss with the LRU victim dirty → WRITEBACK. Otherwise → ALLOCATE.
  - No request: hold state, no outputs asserted.
- WRITEBACK: pmem_write = 1, pmem_address = {victim tag, index, 4'b0}, pmem_wdata = victim line. On pmem_resp → ALLOCATE.
- ALLOCATE: pmem_read = 1, pmem_address = {mem_address[15:4], 4'b0}. On pmem_resp, in the victim way: line = pmem_rdata, tag set, valid = 1, dirty = 0. Then → IDLE, where the request now hits.
- mem_resp is never asserted outside IDLE.
- Both mem_read and mem_write asserted: treated as a write.
- Write with byte_enable = 2'b00: no data change, dirty still set, mem_resp = 1.
- If the CPU drops its request mid-miss, the writeback and fill still complete and the FSM returns to IDLE. There is no abort.

## Timing
- Hit latency: 0 cycles. mem_resp and mem_rdata are combinational from the request in IDLE. Array and LRU updates land on the same rising edge.
- Clean miss: ALLOCATE cycles until pmem_resp, plus one IDLE hit cycle.
- Dirty miss: WRITEBACK cycles + ALLOCATE cycles + one hit cycle.
- pmem_read and pmem_write are never both 1. Each is held steady with a stable address until pmem_resp.
- Reset (asserted at any time, including mid-miss):
  - State → IDLE.
  - All valid, dirty and LRU bits → 0.
  - pmem_read, pmem_write and mem_resp → 0 immediately.
  - pmem_address, pmem_wdata and mem_rdata → 0.
  - Line and tag contents are don't-care.

## Structure
- Add to package lc3b_types: lc3b_c_tag (9b), lc3b_c_index (3b), lc3b_c_offset (4b), lc3b_c_line (128b), and an enum for the FSM states.
- One sub-module, cache_way: a per-way array with asynchronous-read tag, valid, dirty and line storage plus a byte-masked write port. It is instantiated twice.
- The FSM, hit logic, LRU bits and output muxing live in l1_dcache.

## Test plan
- Reset, then read 0x1234 → ALLOCATE with pmem_address 0x1230. Return pmem_rdata with word 2 = 0xBEEF → the next cycle gives mem_resp with mem_rdata 0xBEEF; LRU[3] = 1.
- Read 0x1236 immediately after → mem_resp in the same cycle with no pmem activity.
- Write 0x1234, data 0xAA55, byte_enable 2'b10 → one-cycle resp; a later read of 0x1234 returns 0xAAEF, and the line is dirty.
- Fill set 3 way 1 with tag 0x0A5, then read 0x3234 (set 3, new tag) → WRITEBACK of way 0 at 0x1230 with the modified line, then ALLOCATE at 0x3230.
- Assert rst_n = 0 during ALLOCATE → pmem_read drops at once. After release, a read of 0x1234 misses again.
- Assert mem_read and mem_write together on a hit → the store is performed; no fill occurs.

Source files
------------

// File: rtl/l1_dcache_pkg.sv
// Shared types for the L1 data cache: address fields, line type, FSM states
// and small word-access helpers used by the way arrays and the controller.
package lc3b_types;

    localparam int unsigned C_SETS       = 8;
    localparam int unsigned C_WAYS       = 2;
    localparam int unsigned C_LINE_BITS  = 128;

    typedef logic [8:0]   lc3b_c_tag;
    typedef logic [2:0]   lc3b_c_index;
    typedef logic [3:0]   lc3b_c_offset;
    typedef logic [127:0] lc3b_c_line;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WRITEBACK = 2'd1,
        ST_ALLOCATE  = 2'd2
    } lc3b_c_state_e;

    // Extract 16-bit word 'word' of a line.
    function automatic logic [15:0] get_word(input lc3b_c_line line, input logic [2:0] word);
        return line[{word, 4'b0000} +: 16];
    endfunction

    // Merge a byte-lane aligned store into word 'word' of a line.
    function automatic lc3b_c_line merge_word(input lc3b_c_line line,
                                              input logic [2:0]  word,
                                              input logic [1:0]  be,
                                              input logic [15:0] data);
        lc3b_c_line res;
        res = line;
        res[{word, 4'b0000} +: 8] = be[0] ? data[7:0]  : line[{word, 4'b0000} +: 8];
        res[{word, 4'b1000} +: 8] = be[1] ? data[15:8] : line[{word, 4'b1000} +: 8];
        return res;
    endfunction

endpackage

// File: rtl/l1_dcache_if.sv
// CPU data-memory port and physical-memory port of the L1 data cache.
// 'slave' is the cache's view, 'master' is the surrounding system's view.
interface l1_dcache_if;
    logic         mem_read;
    logic         mem_write;
    logic [15:0]  mem_address;
    logic [15:0]  mem_wdata;
    logic [1:0]   mem_byte_enable;
    logic [15:0]  mem_rdata;
    logic         mem_resp;
    logic         pmem_read;
    logic         pmem_write;
    logic [15:0]  pmem_address;
    logic [127:0] pmem_wdata;
    logic [127:0] pmem_rdata;
    logic         pmem_resp;

    modport slave (
        input  mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        input  pmem_rdata, pmem_resp,
        output mem_rdata, mem_resp,
        output pmem_read, pmem_write, pmem_address, pmem_wdata
    );

    modport master (
        output mem_read, mem_write, mem_address, mem_wdata, mem_byte_enable,
        output pmem_rdata, pmem_resp,
        input  mem_rdata, mem_resp,
        input  pmem_read, pmem_write, pmem_address, pmem_wdata
    );
endinterface

// File: rtl/l1_dcache_way.sv
// One way of the cache: per-set valid, dirty, tag and line storage with
// asynchronous read, a full-line fill port and a byte-masked store port.
module cache_way
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  lc3b_c_index index_i,
    input  logic        fill_en_i,
    input  lc3b_c_tag   fill_tag_i,
    input  lc3b_c_line  fill_line_i,
    input  logic        store_en_i,
    input  logic [2:0]  store_word_i,
    input  logic [1:0]  store_be_i,
    input  logic [15:0] store_data_i,
    output logic        valid_o,
    output logic        dirty_o,
    output lc3b_c_tag   tag_o,
    output lc3b_c_line  line_o
);

    logic [7:0]  valid_q, valid_d;
    logic [7:0]  dirty_q, dirty_d;
    lc3b_c_tag   tag_q  [C_SETS];
    lc3b_c_tag   tag_d  [C_SETS];
    lc3b_c_line  line_q [C_SETS];
    lc3b_c_line  line_d [C_SETS];

    assign valid_o = valid_q[index_i];
    assign dirty_o = dirty_q[index_i];
    assign tag_o   = tag_q[index_i];
    assign line_o  = line_q[index_i];

    // Next-state of the status bits: a fill makes the set valid and clean, a store makes it dirty.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (fill_en_i) begin
            valid_d[index_i] = 1'b1;
            dirty_d[index_i] = 1'b0;
        end else if (store_en_i) begin
            dirty_d[index_i] = 1'b1;
        end else begin
            dirty_d = dirty_q;
        end
    end

    // Next-state of tag and line storage: whole-line fill or byte-masked word store.
    always_comb begin
        tag_d  = tag_q;
        line_d = line_q;
        if (fill_en_i) begin
            tag_d[index_i]  = fill_tag_i;
            line_d[index_i] = fill_line_i;
        end else if (store_en_i) begin
            line_d[index_i] = merge_word(line_q[index_i], store_word_i, store_be_i, store_data_i);
        end else begin
            line_d = line_q;
        end
    end

    // Status bits are cleared by reset so every set starts invalid and clean.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 8'h00;
            dirty_q <= 8'h00;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    // Tag and line contents are meaningless while invalid, so they carry no reset.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        line_q <= line_d;
    end

endmodule

// File: rtl/l1_dcache.sv
// Two-way set-associative write-back / write-allocate L1 data cache.
// Hits complete combinationally in IDLE; misses evict the LRU way, writing it
// back first when dirty, then fill the line from physical memory.
module l1_dcache
    import lc3b_types::*;
(
    input  logic        clk,
    input  logic        rst_n,
    l1_dcache_if.slave  bus
);

    lc3b_c_state_e state_q, state_d;
    logic          pmem_read_q, pmem_read_d;
    logic          pmem_write_q, pmem_write_d;
    logic [15:0]   pmem_address_q, pmem_address_d;
    lc3b_c_line    pmem_wdata_q, pmem_wdata_d;
    logic [11:0]   miss_line_q, miss_line_d;
    logic          victim_q, victim_d;
    logic [7:0]    lru_q, lru_d;

    lc3b_c_tag     req_tag_s;
    lc3b_c_index   req_index_s;
    logic [2:0]    req_word_s;
    lc3b_c_index   way_index_s;
    logic          req_s;
    logic [1:0]    hit_vec_s;
    logic          hit_s;
    logic          hit_way_s;
    lc3b_c_line    hit_line_s;
    logic          victim_s;
    logic          victim_dirty_s;
    lc3b_c_tag     victim_tag_s;
    lc3b_c_line    victim_line_s;
    logic [1:0]    fill_en_s;
    logic [1:0]    store_en_s;
    logic          unused_s;

    logic [1:0]    way_valid_s;
    logic [1:0]    way_dirty_s;
    lc3b_c_tag     way_tag_s  [C_WAYS];
    lc3b_c_line    way_line_s [C_WAYS];

    assign unused_s = bus.mem_address[0];

    // Address decode, hit detection and victim selection.
    always_comb begin
        req_tag_s   = bus.mem_address[15:7];
        req_index_s = bus.mem_address[6:4];
        req_word_s  = bus.mem_address[3:1];
        req_s       = bus.mem_read | bus.mem_write;
        // Outside IDLE the arrays are addressed by the latched miss line.
        way_index_s = (state_q == ST_IDLE) ? req_index_s : miss_line_q[2:0];
        hit_vec_s   = 2'b00;
        if (state_q == ST_IDLE && req_s) begin
            hit_vec_s[0] = way_valid_s[0] && (way_tag_s[0] == req_tag_s);
            hit_vec_s[1] = way_valid_s[1] && (way_tag_s[1] == req_tag_s);
        end else begin
            hit_vec_s = 2'b00;
        end
        hit_s          = |hit_vec_s;
        hit_way_s      = hit_vec_s[1];
        hit_line_s     = hit_way_s ? way_line_s[1] : way_line_s[0];
        victim_s       = lru_q[req_index_s];
        victim_dirty_s = victim_s ? (way_valid_s[1] & way_dirty_s[1])
                                  : (way_valid_s[0] & way_dirty_s[0]);
        victim_tag_s   = victim_s ? way_tag_s[1]  : way_tag_s[0];
        victim_line_s  = victim_s ? way_line_s[1] : way_line_s[0];
    end

    // Array write enables: stores on an IDLE write hit, fills when ALLOCATE completes.
    always_comb begin
        store_en_s = 2'b00;
        fill_en_s  = 2'b00;
        if (hit_s && bus.mem_write) begin
            store_en_s[hit_way_s] = 1'b1;
        end else begin
            store_en_s = 2'b00;
        end
        if (state_q == ST_ALLOCATE && bus.pmem_resp) begin
            fill_en_s[victim_q] = 1'b1;
        end else begin
            fill_en_s = 2'b00;
        end
    end

    cache_way u_way0 (
        .clk          (clk),
        .rst_n        (rst_n),
        .index_i      (way_index_s),
        .fill_en_i    (fill_en_s[0]),
        .fill_tag_i   (miss_line_q[11:3]),
        .fill_line_i  (bus.pmem_rdata),
        .store_en_i   (store_en_s[0]),
        .store_word_i (req_word_s),
        .store_be_i   (bus.mem_byte_enable),
        .store_data_i (bus.mem_wdata),
        .valid_o      (way_valid_s[0]),
        .dirty_o      (way_dirty_s[0]),
        .tag_o        (way_tag_s[0]),
        .line_o       (way_line_s[0])
    );

    cache_way u_way1 (
        .clk          (clk),
        .rst_n        (rst_n),
        .index_i      (way_index_s),
        .fill_en_i    (fill_en_s[1]),
        .fill_tag_i   (miss_line_q[11:3]),
        .fill_line_i  (bus.pmem_rdata),
        .store_en_i   (store_en_s[1]),
        .store_word_i (req_word_s),
        .store_be_i   (bus.mem_byte_enable),
        .store_data_i (bus.mem_wdata),
        .valid_o      (way_valid_s[1]),
        .dirty_o      (way_dirty_s[1]),
        .tag_o        (way_tag_s[1]),
        .line_o       (way_line_s[1])
    );

    // LRU update: any hit makes the other way the next victim.
    always_comb begin
        lru_d = lru_q;
        if (hit_s) begin
            lru_d[req_index_s] = ~hit_way_s;
        end else begin
            lru_d = lru_q;
        end
    end

    // LRU bits reset to way 0 for every set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lru_q <= 8'h00;
        end else begin
            lru_q <= lru_d;
        end
    end

    // Miss FSM next state and next values of the registered pmem outputs.
    always_comb begin
        state_d        = state_q;
        pmem_read_d    = pmem_read_q;
        pmem_write_d   = pmem_write_q;
        pmem_address_d = pmem_address_q;
        pmem_wdata_d   = pmem_wdata_q;
        miss_line_d    = miss_line_q;
        victim_d       = victim_q;
        case (state_q)
            ST_IDLE: begin
                if (req_s && !hit_s) begin
                    // Latch the miss so a dropped request cannot disturb the refill.
                    miss_line_d = bus.mem_address[15:4];
                    victim_d    = victim_s;
                    if (victim_dirty_s) begin
                        state_d        = ST_WRITEBACK;
                        pmem_write_d   = 1'b1;
                        pmem_address_d = {victim_tag_s, req_index_s, 4'h0};
                        pmem_wdata_d   = victim_line_s;
                    end else begin
                        state_d        = ST_ALLOCATE;
                        pmem_read_d    = 1'b1;
                        pmem_address_d = {bus.mem_address[15:4], 4'h0};
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITEBACK: begin
                if (bus.pmem_resp) begin
                    state_d        = ST_ALLOCATE;
                    pmem_write_d   = 1'b0;
                    pmem_read_d    = 1'b1;
                    pmem_address_d = {miss_line_q, 4'h0};
                    pmem_wdata_d   = 128'h0;
                end else begin
                    state_d = ST_WRITEBACK;
                end
            end
            ST_ALLOCATE: begin
                if (bus.pmem_resp) begin
                    state_d        = ST_IDLE;
                    pmem_read_d    = 1'b0;
                    pmem_address_d = 16'h0000;
                end else begin
                    state_d = ST_ALLOCATE;
                end
            end
            default: begin
                state_d        = ST_IDLE;
                pmem_read_d    = 1'b0;
                pmem_write_d   = 1'b0;
                pmem_address_d = 16'h0000;
                pmem_wdata_d   = 128'h0;
            end
        endcase
    end

    // Miss FSM state and registered pmem outputs; reset drops any pmem request at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            pmem_read_q    <= 1'b0;
            pmem_write_q   <= 1'b0;
            pmem_address_q <= 16'h0000;
            pmem_wdata_q   <= 128'h0;
            miss_line_q    <= 12'h000;
            victim_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            pmem_read_q    <= pmem_read_d;
            pmem_write_q   <= pmem_write_d;
            pmem_address_q <= pmem_address_d;
            pmem_wdata_q   <= pmem_wdata_d;
            miss_line_q    <= miss_line_d;
            victim_q       <= victim_d;
        end
    end

    assign bus.mem_resp     = hit_s;
    assign bus.mem_rdata    = hit_s ? get_word(hit_line_s, req_word_s) : 16'h0000;
    assign bus.pmem_read    = pmem_read_q;
    assign bus.pmem_write   = pmem_write_q;
    assign bus.pmem_address = pmem_address_q;
    assign bus.pmem_wdata   = pmem_wdata_q;

endmodule

// File: tb/tb_l1_dcache.sv
// Directed scoreboard bench for l1_dcache: expected read data and expected
// physical-memory transactions are queued as stimulus is issued and checked
// when the cache answers or requests memory.
module tb_l1_dcache;

    typedef struct packed {
        logic         wr;
        logic [15:0]  addr;
        logic [127:0] data;
    } pm_txn_t;

    localparam logic [127:0] LINE_A =
        {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'hBEEF, 16'h1111, 16'h0000};
    localparam logic [127:0] LINE_A_MOD =
        {16'h7777, 16'h6666, 16'h5555, 16'h4444, 16'h3333, 16'hAAEF, 16'h1111, 16'h0000};

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   cyc;
    int   ntx;

    pm_txn_t      pm_exp_q [$];
    logic [15:0]  rd_exp_q [$];
    logic [127:0] pmem_model [logic [15:0]];

    l1_dcache_if bus ();

    l1_dcache dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [127:0] mem_lookup(input logic [15:0] a);
        if (pmem_model.exists(a)) return pmem_model[a];
        return {8{a}};
    endfunction

    task automatic exp_pm(input logic wr, input logic [15:0] addr, input logic [127:0] data);
        pm_txn_t e;
        e.wr = wr; e.addr = addr; e.data = data;
        pm_exp_q.push_back(e);
    endtask

    // Issue one CPU request, serve physical memory with a two-cycle latency,
    // and check results against the queued expectations.
    task automatic cpu_req(input string tag, input logic rd, input logic wr,
                           input logic [15:0] addr, input logic [15:0] wdata,
                           input logic [1:0] be, output int cycles, output int n_txn);
        logic    done;
        int      wait_c;
        pm_txn_t e;
        bus.mem_read = rd; bus.mem_write = wr; bus.mem_address = addr;
        bus.mem_wdata = wdata; bus.mem_byte_enable = be;
        cycles = 0; n_txn = 0; done = 1'b0; wait_c = 0;
        while (!done && cycles < 60) begin
            @(negedge clk);
            cycles++;
            if (bus.mem_resp) begin
                if (rd && !wr) begin
                    check({tag, "/rd_expected"}, 128'(rd_exp_q.size() > 0), 128'(1'b1));
                    if (rd_exp_q.size() > 0)
                        check({tag, "/rdata"}, 128'(bus.mem_rdata), 128'(rd_exp_q.pop_front()));
                end
                done = 1'b1;
            end else if (bus.pmem_read || bus.pmem_write) begin
                wait_c++;
                if (wait_c == 2) begin
                    n_txn++;
                    check({tag, "/pmem_excl"}, 128'(bus.pmem_read & bus.pmem_write), 128'(1'b0));
                    check({tag, "/pm_expected"}, 128'(pm_exp_q.size() > 0), 128'(1'b1));
                    if (pm_exp_q.size() > 0) begin
                        e = pm_exp_q.pop_front();
                        check({tag, "/pm_kind"}, 128'(bus.pmem_write), 128'(e.wr));
                        check({tag, "/pm_addr"}, 128'(bus.pmem_address), 128'(e.addr));
                        if (e.wr) check({tag, "/pm_wdata"}, bus.pmem_wdata, e.data);
                    end
                    if (bus.pmem_write) pmem_model[bus.pmem_address] = bus.pmem_wdata;
                    else bus.pmem_rdata = mem_lookup(bus.pmem_address);
                    bus.pmem_resp = 1'b1;
                    @(posedge clk);
                    #1 bus.pmem_resp = 1'b0;
                    wait_c = 0;
                end
            end
        end
        check({tag, "/completed"}, 128'(done), 128'(1'b1));
        @(posedge clk);
        #1;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.mem_address = 16'h0000;
        bus.mem_wdata = 16'h0000; bus.mem_byte_enable = 2'b00;
        bus.pmem_rdata = 128'h0; bus.pmem_resp = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst/mem_resp", 128'(bus.mem_resp), 128'(1'b0));
        check("rst/pmem_read", 128'(bus.pmem_read), 128'(1'b0));
        check("rst/pmem_write", 128'(bus.pmem_write), 128'(1'b0));
        check("rst/pmem_address", 128'(bus.pmem_address), 128'(16'h0000));
        check("rst/pmem_wdata", bus.pmem_wdata, 128'h0);
        check("rst/mem_rdata", 128'(bus.mem_rdata), 128'(16'h0000));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Clean miss then hit on the filled line.
        pmem_model[16'h1230] = LINE_A;
        exp_pm(1'b0, 16'h1230, 128'h0);
        rd_exp_q.push_back(16'hBEEF);
        cpu_req("rd1234_miss", 1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, cyc, ntx);
        check("rd1234_miss/cycles", 128'(cyc), 128'(4));
        check("rd1234_miss/txns", 128'(ntx), 128'(1));

        rd_exp_q.push_back(16'h3333);
        cpu_req("rd1236_hit", 1'b1, 1'b0, 16'h1236, 16'h0000, 2'b00, cyc, ntx);
        check("rd1236_hit/cycles", 128'(cyc), 128'(1));
        check("rd1236_hit/txns", 128'(ntx), 128'(0));

        // High-byte store hit.
        cpu_req("wr1234_hi", 1'b0, 1'b1, 16'h1234, 16'hAA55, 2'b10, cyc, ntx);
        check("wr1234_hi/cycles", 128'(cyc), 128'(1));
        rd_exp_q.push_back(16'hAAEF);
        cpu_req("rd1234_after_wr", 1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, cyc, ntx);
        check("rd1234_after_wr/txns", 128'(ntx), 128'(0));

        // Fill set 3 way 1 (LRU points there), then a dirty eviction of way 0.
        exp_pm(1'b0, 16'h52B0, 128'h0);
        rd_exp_q.push_back(16'h52B0);
        cpu_req("rd52B0_fill_way1", 1'b1, 1'b0, 16'h52B0, 16'h0000, 2'b00, cyc, ntx);
        check("rd52B0_fill_way1/txns", 128'(ntx), 128'(1));

        exp_pm(1'b1, 16'h1230, LINE_A_MOD);
        exp_pm(1'b0, 16'h3230, 128'h0);
        rd_exp_q.push_back(16'h3230);
        cpu_req("rd3234_dirty_miss", 1'b1, 1'b0, 16'h3234, 16'h0000, 2'b00, cyc, ntx);
        check("rd3234_dirty_miss/cycles", 128'(cyc), 128'(6));
        check("rd3234_dirty_miss/txns", 128'(ntx), 128'(2));

        // Reset in the middle of ALLOCATE.
        bus.mem_read = 1'b1; bus.mem_address = 16'h1234;
        repeat (2) @(negedge clk);
        check("alloc/pmem_read", 128'(bus.pmem_read), 128'(1'b1));
        check("alloc/pmem_address", 128'(bus.pmem_address), 128'(16'h1230));
        check("alloc/mem_resp", 128'(bus.mem_resp), 128'(1'b0));
        rst_n = 1'b0;
        #1;
        check("midrst/pmem_read", 128'(bus.pmem_read), 128'(1'b0));
        check("midrst/pmem_address", 128'(bus.pmem_address), 128'(16'h0000));
        check("midrst/mem_resp", 128'(bus.mem_resp), 128'(1'b0));
        check("midrst/mem_rdata", 128'(bus.mem_rdata), 128'(16'h0000));
        bus.mem_read = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // After reset the line is gone; the refill returns the written-back data.
        exp_pm(1'b0, 16'h1230, 128'h0);
        rd_exp_q.push_back(16'hAAEF);
        cpu_req("rd1234_after_rst", 1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, cyc, ntx);
        check("rd1234_after_rst/txns", 128'(ntx), 128'(1));

        // Read and write together act as a write.
        cpu_req("rdwr1234", 1'b1, 1'b1, 16'h1234, 16'h1357, 2'b11, cyc, ntx);
        check("rdwr1234/cycles", 128'(cyc), 128'(1));
        check("rdwr1234/txns", 128'(ntx), 128'(0));
        rd_exp_q.push_back(16'h1357);
        cpu_req("rd1234_after_rdwr", 1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, cyc, ntx);

        // Empty byte mask leaves data alone; low-byte store.
        cpu_req("wr1236_be00", 1'b0, 1'b1, 16'h1236, 16'hFFFF, 2'b00, cyc, ntx);
        check("wr1236_be00/cycles", 128'(cyc), 128'(1));
        rd_exp_q.push_back(16'h3333);
        cpu_req("rd1236_after_be00", 1'b1, 1'b0, 16'h1236, 16'h0000, 2'b00, cyc, ntx);
        cpu_req("wr1238_lo", 1'b0, 1'b1, 16'h1238, 16'h00CD, 2'b01, cyc, ntx);
        rd_exp_q.push_back(16'h44CD);
        cpu_req("rd1238_after_lo", 1'b1, 1'b0, 16'h1238, 16'h0000, 2'b00, cyc, ntx);

        // A be=00 store still dirties the line: its later eviction writes it back.
        exp_pm(1'b0, 16'h52B0, 128'h0);
        rd_exp_q.push_back(16'h52B0);
        cpu_req("rd52B0_refill", 1'b1, 1'b0, 16'h52B0, 16'h0000, 2'b00, cyc, ntx);
        cpu_req("wr52B0_be00", 1'b0, 1'b1, 16'h52B0, 16'hFFFF, 2'b00, cyc, ntx);
        rd_exp_q.push_back(16'h1357);
        cpu_req("rd1234_touch", 1'b1, 1'b0, 16'h1234, 16'h0000, 2'b00, cyc, ntx);
        exp_pm(1'b1, 16'h52B0, {8{16'h52B0}});
        exp_pm(1'b0, 16'h3230, 128'h0);
        rd_exp_q.push_back(16'h3230);
        cpu_req("rd3234_evict_be00", 1'b1, 1'b0, 16'h3234, 16'h0000, 2'b00, cyc, ntx);
        check("rd3234_evict_be00/txns", 128'(ntx), 128'(2));

        check("end/pm_queue_empty", 128'(pm_exp_q.size()), 128'(0));
        check("end/rd_queue_empty", 128'(rd_exp_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
